// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of one shared bitwise logic unit.
// Each request runs IDLE -> EXEC -> RESP; the result is held until the consumer accepts it.
module logic_unit_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_x0,
  input  logic [WIDTH-1:0] req_y0,
  input  logic [WIDTH-1:0] req_x1,
  input  logic [WIDTH-1:0] req_y1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_prio;
  op_t              r_op;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic [15:0]      r_op_count;

  logic             w_grant;
  logic             w_grant_id;
  logic [1:0]       w_ready;
  logic [WIDTH-1:0] w_result;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_id   = 1'b0;
    w_ready      = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_grant      = 1'b1;
          // A lone requester wins outright; a tie goes to the requester named by prio.
          w_grant_id   = (req_valid == 2'b11) ? r_prio : req_valid[1];
          w_ready      = w_grant_id ? 2'b10 : 2'b01;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_OR:   w_result = r_x | r_y;
      OP_AND:  w_result = r_x & r_y;
      OP_XOR:  w_result = r_x ^ r_y;
      OP_NOR:  w_result = ~(r_x | r_y);
      default: w_result = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio      <= 1'b0;
      r_op        <= OP_OR;
      r_x         <= '0;
      r_y         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            // Operands are captured here so later requester activity cannot disturb the result.
            r_op   <= op_t'(w_grant_id ? req_op1 : req_op0);
            r_x    <= w_grant_id ? req_x1 : req_x0;
            r_y    <= w_grant_id ? req_y1 : req_y0;
            r_id   <= w_grant_id;
            r_prio <= ~w_grant_id;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Grants are gated by rst_n so req_ready stays low for the whole reset, not just after an edge.
  assign req_ready = w_ready & {2{rst_n}};
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != ST_IDLE);
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0, req_op1;
  logic [WIDTH-1:0] req_x0, req_y0, req_x1, req_y1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic [15:0]      op_count;

  int errors = 0;
  int checks = 0;
  logic grant_q[$];

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_x0    (req_x0),
    .req_y0    (req_y0),
    .req_x1    (req_x1),
    .req_y1    (req_y1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (op)
      2'b00:   return x | y;
      2'b01:   return x & y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Transaction model: one request in flight; its result appears one edge after
  // acceptance and retires on the first edge where the consumer is ready.
  logic             m_inflight;
  logic             m_produced;
  logic             m_prio;
  logic             m_pend_id;
  logic [WIDTH-1:0] m_pend_res;
  logic             m_rsp_id;
  logic [WIDTH-1:0] m_rsp_data;
  logic [15:0]      m_count;
  logic             m_win;

  assign m_win = (req_valid == 2'b11) ? m_prio : req_valid[1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0;
      m_produced <= 1'b0;
      m_prio     <= 1'b0;
      m_pend_id  <= 1'b0;
      m_pend_res <= '0;
      m_rsp_id   <= 1'b0;
      m_rsp_data <= '0;
      m_count    <= '0;
    end else if (!m_inflight) begin
      if (req_valid != 2'b00) begin
        m_inflight <= 1'b1;
        m_produced <= 1'b0;
        m_pend_id  <= m_win;
        m_pend_res <= m_win ? apply_op(req_op1, req_x1, req_y1) : apply_op(req_op0, req_x0, req_y0);
        m_prio     <= ~m_win;
      end
    end else if (!m_produced) begin
      m_produced <= 1'b1;
      m_rsp_id   <= m_pend_id;
      m_rsp_data <= m_pend_res;
    end else if (rsp_ready) begin
      m_inflight <= 1'b0;
      m_produced <= 1'b0;
      m_count    <= m_count + 16'd1;
    end
  end

  function automatic logic [1:0] model_ready();
    if (m_inflight || req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_req_ready", {62'd0, req_ready}, {62'd0, model_ready()});
      check("cyc_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_inflight && m_produced});
      check("cyc_rsp_id",    {63'd0, rsp_id},    {63'd0, m_rsp_id});
      check("cyc_rsp_data",  rsp_data,           m_rsp_data);
      check("cyc_busy",      {63'd0, busy},      {63'd0, m_inflight});
      check("cyc_op_count",  {48'd0, op_count},  {48'd0, m_count});
      if (req_ready != 2'b00) grant_q.push_back(req_ready[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [WIDTH-1:0] held_data;

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
    rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_op_count",  {48'd0, op_count},  64'd0);
    check("rst_rsp_data",  rsp_data,           64'd0);
    step(1);

    // Lone req0 OR; first grant is available on the first edge after reset release.
    rst_n = 1'b1;
    req_valid = 2'b01;
    req_op0 = 2'b00;
    req_x0 = 64'h1334_5678_4ACB_CF77;
    req_y0 = 64'hFEEC_B209_8755_D301;
    #1;
    check("s1_ready", {62'd0, req_ready}, 64'd1);
    step(1);
    req_valid = 2'b00;
    req_x0 = 64'hDEAD_BEEF_0000_0000;
    req_y0 = '0;
    req_op0 = 2'b01;
    check("s1_not_yet_valid", {63'd0, rsp_valid}, 64'd0);
    check("s1_busy", {63'd0, busy}, 64'd1);
    step(1);
    check("s1_valid", {63'd0, rsp_valid}, 64'd1);
    check("s1_data", rsp_data, 64'hFFFC_F679_CFDF_DF77);
    check("s1_id", {63'd0, rsp_id}, 64'd0);
    step(1);
    check("s1_done_valid", {63'd0, rsp_valid}, 64'd0);
    check("s1_count", {48'd0, op_count}, 64'd1);

    // Tie right after reset: req0 first, then req1.
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_op0 = 2'b01; req_x0 = ONES; req_y0 = 64'd1;
    req_op1 = 2'b10; req_x1 = ONES; req_y1 = ONES;
    #1;
    grant_q.delete();
    rst_n = 1'b1;
    step(2);
    check("s2_first_id", {63'd0, rsp_id}, 64'd0);
    check("s2_first_data", rsp_data, 64'd1);
    step(3);
    check("s2_second_id", {63'd0, rsp_id}, 64'd1);
    check("s2_second_data", rsp_data, 64'd0);
    step(1);
    check("s2_count", {48'd0, op_count}, 64'd2);
    check("s2_grants", {62'd0, 2'(grant_q.size())}, 64'd2);
    if (grant_q.size() == 2) check("s2_order", {62'd0, grant_q[0], grant_q[1]}, 64'b01);

    // Both held valid for six grants: strict alternation starting with req0.
    grant_q.delete();
    step(18);
    req_valid = 2'b00;
    check("s3_grants", {32'd0, 32'(grant_q.size())}, 64'd6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++)
      check($sformatf("s3_grant%0d", i), {63'd0, grant_q[i]}, {63'd0, 1'(i % 2)});
    check("s3_count", {48'd0, op_count}, 64'd8);

    // req1 NOR of zeros with consumer stalled for five cycles.
    req_valid = 2'b10;
    req_op1 = 2'b11; req_x1 = '0; req_y1 = '0;
    rsp_ready = 1'b0;
    step(1);
    req_valid = 2'b00;
    step(1);
    check("s4_data", rsp_data, ONES);
    check("s4_id", {63'd0, rsp_id}, 64'd1);
    held_data = rsp_data;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("s4_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("s4_hold_data", rsp_data, held_data);
      check("s4_hold_id", {63'd0, rsp_id}, 64'd1);
      check("s4_hold_ready", {62'd0, req_ready}, 64'd0);
      check("s4_hold_busy", {63'd0, busy}, 64'd1);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step(1);
    check("s4_done_valid", {63'd0, rsp_valid}, 64'd0);
    check("s4_done_busy", {63'd0, busy}, 64'd0);
    check("s4_count", {48'd0, op_count}, 64'd9);

    // Reset in RESP drops the response; prio returns to req0.
    req_valid = 2'b01;
    req_op0 = 2'b10; req_x0 = 64'h0F0F_0F0F_0F0F_0F0F; req_y0 = ONES;
    rsp_ready = 1'b0;
    step(1);
    req_valid = 2'b00;
    step(1);
    check("s5_pre_valid", {63'd0, rsp_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("s5_rst_busy", {63'd0, busy}, 64'd0);
    check("s5_rst_count", {48'd0, op_count}, 64'd0);
    req_valid = 2'b11;
    req_op0 = 2'b00; req_x0 = 64'h00FF; req_y0 = 64'hFF00;
    #1;
    check("s5_rst_ready", {62'd0, req_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("s5_tie_ready", {62'd0, req_ready}, 64'd1);
    rsp_ready = 1'b1;
    step(1);
    req_valid = 2'b00;
    step(1);
    check("s5_id", {63'd0, rsp_id}, 64'd0);
    check("s5_data", rsp_data, 64'hFFFF);
    step(1);
    check("s5_count", {48'd0, op_count}, 64'd1);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
